alu: RTL and testbench
======================

# alu

Sequential arithmetic/logic unit that drives the accumulator write port: it samples the current accumulator value and a memory operand on a start strobe, computes single-cycle or multi-cycle (16-step shift-add multiply) results, and presents the result on `alu2acc` with a one-cycle `acc_alu_io_rw` write strobe. It sits between the control unit (start/opcode/done handshake) and the ACC register. It also exposes a multiply high-word register and status flags to the control unit.

## Interface
- Parameters: none (data width fixed at 16).
- `clk`  in  1  system clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `alu_start`  in  1  one-cycle request; sampled only in IDLE.
- `alu_op`  in  4  opcode, sampled with `alu_start`.
- `acc_data`  in  16  current ACC value (operand A).
- `mbr2alu`  in  16  memory buffer operand (operand B).
- `alu2acc`  out  16  result to ACC; valid while `acc_alu_io_rw`=1.
- `acc_alu_io_rw`  out  1  ACC write strobe, 1 = write ACC, 0 = read ACC.
- `mr_data`  out  16  high word of last MPY product.
- `alu_busy`  out  1  high from the cycle after accepted start through the write cycle.
- `alu_done`  out  1  one-cycle completion pulse.
- `flags`  out  4  {Z, N, C, V}, registered at completion.

## Operation
- Opcodes: 0 ADD (A+B), 1 SUB (A−B), 2 AND, 3 OR, 4 NOT (~A), 5 SHL (A<<1), 6 SHR (logical A>>1), 7 MPY (unsigned A×B), 8 LOAD (B), 9–15 illegal.
- States: IDLE, EXEC, MUL, WB.
- IDLE: on `alu_start`=1 latch A, B, op → EXEC if op≠7, MUL if op=7.
- EXEC: compute result combinationally from latched operands → WB.
- MUL: 16 iterations, one per cycle, shift-add on a 32-bit product register with a 5-bit counter; after 16th iteration → WB.
- WB: `acc_alu_io_rw`=1, `alu2acc`=result, `alu_done`=1, flags updated; MPY also loads `mr_data`=product[31:16] → IDLE.
- Arithmetic: ADD/SUB use a 17-bit sum; C = bit 16 for ADD, C = borrow (A<B unsigned) for SUB; V = signed overflow for ADD/SUB, 0 otherwise. SHL C = A[15]; SHR C = A[0]; MPY C = (product[31:16]≠0); other ops C=0. Z = (result==0), N = result[15].
- Illegal opcode: goes through EXEC → WB but `acc_alu_io_rw` stays 0; `alu_done` still pulses; flags and `mr_data` unchanged.
- `alu_start` while not IDLE: ignored, no queuing.
- Reset (any time, including mid-MUL): state IDLE, all registers cleared; outputs `alu2acc`=0, `acc_alu_io_rw`=0, `mr_data`=0, `alu_busy`=0, `alu_done`=0, `flags`=0.
- Outputs `acc_alu_io_rw`, `alu_done`, `alu_busy` are registered/state-decoded, no combinational path from `alu_start`.

## Timing
- Start sampled at edge E0 (cycle 0).
- Single-cycle ops: EXEC in cycle 1, WB in cycle 2; ACC captures on edge ending cycle 2. Latency start→ACC update = 3 edges.
- MPY: MUL cycles 1–16, WB cycle 17; ACC update at edge ending cycle 17.
- `alu_busy`=1 cycles 1..WB inclusive; new start accepted earliest in cycle after WB.
- `alu2acc` held at 0 outside WB.
- Operands changing after E0 do not affect the result.

## Structure
- Shared package: opcode constants (OP_ADD..OP_LOAD), state encoding, flag bit indices, data width constant 16.
- One sub-module natural: `alu_mul16`, 16-cycle unsigned shift-add multiplier with start/done; rest in `alu`.

## Test plan
- Reset mid-MPY (assert `rst_n`=0 in cycle 8) → all outputs 0, IDLE; subsequent ADD works normally.
- ADD A=16'h7FFF, B=16'h0001 → WB cycle 2, `alu2acc`=16'h8000, flags Z=0 N=1 C=0 V=1.
- SUB A=16'h0003, B=16'h0005 → `alu2acc`=16'hFFFE, C=1, N=1, V=0; SHR A=16'h0001 → 16'h0000, Z=1, C=1.
- MPY A=16'h1234, B=16'h0100 → write in cycle 17, `alu2acc`=16'h3400, `mr_data`=16'h0012, C=1; `alu_busy` high cycles 1–17.
- `alu_start` pulses during MPY cycle 5 → ignored, exactly one `alu_done`; back-to-back start in cycle after WB accepted.
- Illegal op 4'hC → `alu_done` in cycle 2, `acc_alu_io_rw` never 1, flags and `mr_data` unchanged.

Source files
------------

// File: rtl/alu_pkg.sv
// ============================================================================
// Module      : alu_pkg
// Description : Shared opcodes, state encoding, flag indices and flag packing
//               helper for the accumulator-side ALU.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package alu_pkg;

    localparam int DATA_W = 16;

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_AND  = 4'd2;
    localparam logic [3:0] OP_OR   = 4'd3;
    localparam logic [3:0] OP_NOT  = 4'd4;
    localparam logic [3:0] OP_SHL  = 4'd5;
    localparam logic [3:0] OP_SHR  = 4'd6;
    localparam logic [3:0] OP_MPY  = 4'd7;
    localparam logic [3:0] OP_LOAD = 4'd8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_MUL  = 2'd2,
        ST_WB   = 2'd3
    } alu_state_e;

    localparam int FLAG_Z = 3;
    localparam int FLAG_N = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    function automatic logic [3:0] make_flags(input logic [DATA_W-1:0] res,
                                              input logic c, input logic v);
        logic [3:0] f;
        f         = '0;
        f[FLAG_Z] = (res == '0);
        f[FLAG_N] = res[DATA_W-1];
        f[FLAG_C] = c;
        f[FLAG_V] = v;
        return f;
    endfunction

endpackage

`default_nettype wire

// File: rtl/alu_if.sv
// ============================================================================
// Module      : alu_if
// Description : Control-unit / ACC facing bundle of the ALU.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface alu_if;
    import alu_pkg::*;

    logic              alu_start;
    logic [3:0]        alu_op;
    logic [DATA_W-1:0] acc_data;
    logic [DATA_W-1:0] mbr2alu;
    logic [DATA_W-1:0] alu2acc;
    logic              acc_alu_io_rw;
    logic [DATA_W-1:0] mr_data;
    logic              alu_busy;
    logic              alu_done;
    logic [3:0]        flags;

    modport master (
        output alu_start, alu_op, acc_data, mbr2alu,
        input  alu2acc, acc_alu_io_rw, mr_data, alu_busy, alu_done, flags
    );

    modport slave (
        input  alu_start, alu_op, acc_data, mbr2alu,
        output alu2acc, acc_alu_io_rw, mr_data, alu_busy, alu_done, flags
    );

endinterface

`default_nettype wire

// File: rtl/alu_mul16.sv
// ============================================================================
// Module      : alu_mul16
// Description : 16-step unsigned shift-add multiplier, one iteration per cycle.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_mul16
    import alu_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start_i,
    input  logic [DATA_W-1:0]   a_i,
    input  logic [DATA_W-1:0]   b_i,
    output logic                done_o,
    output logic [2*DATA_W-1:0] product_o
);

    logic [2*DATA_W-1:0] prod_q;
    logic [DATA_W-1:0]   mcand_q;
    logic [4:0]          cnt_q;
    logic                run_q;

    logic [DATA_W:0]     sum_d;
    logic [2*DATA_W-1:0] prod_d;

    // Multiplier sits in the low half and is consumed LSB-first as the product shifts right
    always_comb begin
        sum_d  = {1'b0, prod_q[2*DATA_W-1:DATA_W]} + (prod_q[0] ? {1'b0, mcand_q} : '0);
        prod_d = {sum_d, prod_q[DATA_W-1:1]};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prod_q  <= '0;
            mcand_q <= '0;
            cnt_q   <= '0;
            run_q   <= 1'b0;
        end else if (start_i) begin
            prod_q  <= {{DATA_W{1'b0}}, b_i};
            mcand_q <= a_i;
            cnt_q   <= '0;
            run_q   <= 1'b1;
        end else if (run_q) begin
            prod_q <= prod_d;
            cnt_q  <= cnt_q + 5'd1;
            if (cnt_q == 5'd15) begin
                run_q <= 1'b0;
            end
        end
    end

    // Done flags the 16th iteration; product_o then already carries its result
    assign done_o    = run_q && (cnt_q == 5'd15);
    assign product_o = prod_d;

endmodule

`default_nettype wire

// File: rtl/alu.sv
// ============================================================================
// Module      : alu
// Description : Sequential ALU feeding the ACC write port (IDLE/EXEC/MUL/WB).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu
    import alu_pkg::*;
(
    input  logic  clk,
    input  logic  rst_n,
    alu_if.slave  bus
);

    alu_state_e          state_q;
    logic [DATA_W-1:0]   a_q, b_q;
    logic [3:0]          op_q;
    logic [DATA_W-1:0]   alu2acc_q, mr_q;
    logic [3:0]          flags_q;
    logic                rw_q, busy_q, done_q;

    logic [DATA_W:0]     sum_d;
    logic [DATA_W-1:0]   res_d;
    logic                c_d, v_d, legal_d;
    logic                mul_start_d, mul_done;
    logic [2*DATA_W-1:0] mul_prod;

    assign mul_start_d = (state_q == ST_IDLE) && bus.alu_start && (bus.alu_op == OP_MPY);

    alu_mul16 u_mul (
        .clk       (clk),
        .rst_n     (rst_n),
        .start_i   (mul_start_d),
        .a_i       (bus.acc_data),
        .b_i       (bus.mbr2alu),
        .done_o    (mul_done),
        .product_o (mul_prod)
    );

    always_comb begin
        sum_d   = '0;
        res_d   = '0;
        c_d     = 1'b0;
        v_d     = 1'b0;
        legal_d = 1'b1;
        case (op_q)
            OP_ADD: begin
                sum_d = {1'b0, a_q} + {1'b0, b_q};
                res_d = sum_d[DATA_W-1:0];
                c_d   = sum_d[DATA_W];
                v_d   = (a_q[DATA_W-1] == b_q[DATA_W-1]) && (res_d[DATA_W-1] != a_q[DATA_W-1]);
            end
            OP_SUB: begin
                // Bit 16 of the 17-bit difference is the unsigned borrow
                sum_d = {1'b0, a_q} - {1'b0, b_q};
                res_d = sum_d[DATA_W-1:0];
                c_d   = sum_d[DATA_W];
                v_d   = (a_q[DATA_W-1] != b_q[DATA_W-1]) && (res_d[DATA_W-1] != a_q[DATA_W-1]);
            end
            OP_AND:  res_d = a_q & b_q;
            OP_OR:   res_d = a_q | b_q;
            OP_NOT:  res_d = ~a_q;
            OP_SHL: begin
                res_d = {a_q[DATA_W-2:0], 1'b0};
                c_d   = a_q[DATA_W-1];
            end
            OP_SHR: begin
                res_d = {1'b0, a_q[DATA_W-1:1]};
                c_d   = a_q[0];
            end
            OP_LOAD: res_d = b_q;
            default: legal_d = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            a_q       <= '0;
            b_q       <= '0;
            op_q      <= '0;
            alu2acc_q <= '0;
            mr_q      <= '0;
            flags_q   <= '0;
            rw_q      <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.alu_start) begin
                        a_q     <= bus.acc_data;
                        b_q     <= bus.mbr2alu;
                        op_q    <= bus.alu_op;
                        busy_q  <= 1'b1;
                        state_q <= (bus.alu_op == OP_MPY) ? ST_MUL : ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    // Illegal opcodes still complete, but leave ACC, flags and MR alone
                    done_q  <= 1'b1;
                    state_q <= ST_WB;
                    if (legal_d) begin
                        rw_q      <= 1'b1;
                        alu2acc_q <= res_d;
                        flags_q   <= make_flags(res_d, c_d, v_d);
                    end
                end
                ST_MUL: begin
                    if (mul_done) begin
                        done_q    <= 1'b1;
                        rw_q      <= 1'b1;
                        alu2acc_q <= mul_prod[DATA_W-1:0];
                        mr_q      <= mul_prod[2*DATA_W-1:DATA_W];
                        flags_q   <= make_flags(mul_prod[DATA_W-1:0],
                                                |mul_prod[2*DATA_W-1:DATA_W], 1'b0);
                        state_q   <= ST_WB;
                    end
                end
                ST_WB: begin
                    done_q    <= 1'b0;
                    rw_q      <= 1'b0;
                    busy_q    <= 1'b0;
                    alu2acc_q <= '0;
                    state_q   <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign bus.alu2acc       = alu2acc_q;
    assign bus.acc_alu_io_rw = rw_q;
    assign bus.mr_data       = mr_q;
    assign bus.alu_busy      = busy_q;
    assign bus.alu_done      = done_q;
    assign bus.flags         = flags_q;

endmodule

`default_nettype wire

// File: tb/tb_alu.sv
// ============================================================================
// Module      : tb_alu
// Description : Directed self-checking bench for the accumulator ALU.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_alu;
    import alu_pkg::*;

    logic clk;
    logic rst_n;
    int   n_vec;
    int   n_err;

    alu_if bus ();

    alu dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one start strobe, then scramble operands so late changes would show up
    task automatic issue(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
        @(negedge clk);
        bus.alu_start = 1'b1;
        bus.alu_op    = op;
        bus.acc_data  = a;
        bus.mbr2alu   = b;
        @(negedge clk);
        bus.alu_start = 1'b0;
        bus.alu_op    = 4'hF;
        bus.acc_data  = 16'hA5A5;
        bus.mbr2alu   = 16'h5A5A;
    endtask

    // Called in cycle 1; returns parked on the negedge of the done cycle
    task automatic wait_done(input int inject, output int cyc, output int busy_n,
                             output bit rw_early);
        cyc      = -1;
        busy_n   = 0;
        rw_early = 1'b0;
        for (int k = 1; k <= 40 && cyc < 0; k++) begin
            if (k > 1) @(negedge clk);
            if (k == inject + 1) bus.alu_start = 1'b0;
            if (k == inject) begin
                bus.alu_start = 1'b1;
                bus.alu_op    = OP_ADD;
            end
            if (bus.alu_busy === 1'b1) busy_n++;
            if (bus.alu_done === 1'b1) cyc = k;
            else if (bus.acc_alu_io_rw === 1'b1) rw_early = 1'b1;
        end
        bus.alu_start = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        n_vec++;
        if ({bus.alu2acc, bus.mr_data} !== 32'h0) begin
            n_err++;
            $display("FAIL reset_data: got %h/%h want 0000/0000", bus.alu2acc, bus.mr_data);
        end
        n_vec++;
        if ({bus.acc_alu_io_rw, bus.alu_busy, bus.alu_done, bus.flags} !== 7'h0) begin
            n_err++;
            $display("FAIL reset_ctl: got rw=%b busy=%b done=%b flags=%b want all 0",
                     bus.acc_alu_io_rw, bus.alu_busy, bus.alu_done, bus.flags);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_add_overflow();
        int cyc, busy_n;
        bit rw_early;
        issue(OP_ADD, 16'h7FFF, 16'h0001);
        wait_done(0, cyc, busy_n, rw_early);
        n_vec++;
        if (cyc !== 2 || busy_n !== 2 || rw_early !== 1'b0) begin
            n_err++;
            $display("FAIL add_timing: got done_cyc=%0d busy=%0d early_rw=%b want 2/2/0",
                     cyc, busy_n, rw_early);
        end
        n_vec++;
        if (bus.alu2acc !== 16'h8000 || bus.acc_alu_io_rw !== 1'b1) begin
            n_err++;
            $display("FAIL add_result: got %h rw=%b want 8000 rw=1", bus.alu2acc, bus.acc_alu_io_rw);
        end
        n_vec++;
        if (bus.flags !== 4'b0101) begin
            n_err++;
            $display("FAIL add_flags: got %b want 0101", bus.flags);
        end
        @(negedge clk);
        n_vec++;
        if ({bus.alu2acc, bus.acc_alu_io_rw, bus.alu_busy, bus.alu_done} !== 19'h0) begin
            n_err++;
            $display("FAIL add_after_wb: got acc=%h rw=%b busy=%b done=%b want 0",
                     bus.alu2acc, bus.acc_alu_io_rw, bus.alu_busy, bus.alu_done);
        end
    endtask

    task automatic test_sub_shr();
        int cyc, busy_n;
        bit rw_early;
        issue(OP_SUB, 16'h0003, 16'h0005);
        wait_done(0, cyc, busy_n, rw_early);
        n_vec++;
        if (cyc !== 2 || bus.alu2acc !== 16'hFFFE || bus.flags !== 4'b0110) begin
            n_err++;
            $display("FAIL sub: got cyc=%0d acc=%h flags=%b want 2 FFFE 0110",
                     cyc, bus.alu2acc, bus.flags);
        end
        issue(OP_SHR, 16'h0001, 16'hFFFF);
        wait_done(0, cyc, busy_n, rw_early);
        n_vec++;
        if (cyc !== 2 || bus.alu2acc !== 16'h0000 || bus.flags !== 4'b1010) begin
            n_err++;
            $display("FAIL shr: got cyc=%0d acc=%h flags=%b want 2 0000 1010",
                     cyc, bus.alu2acc, bus.flags);
        end
    endtask

    task automatic test_logic_ops();
        logic [3:0]  ops [6];
        logic [15:0] exp_r [6];
        logic [3:0]  exp_f [6];
        int cyc, busy_n;
        bit rw_early;
        ops   = '{OP_AND, OP_OR, OP_NOT, OP_SHL, OP_LOAD, OP_ADD};
        exp_r = '{16'h0000, 16'hCFFF, 16'h3FF0, 16'h801E, 16'h0FF0, 16'hCFFF};
        exp_f = '{4'b1000, 4'b0100, 4'b0000, 4'b0110, 4'b0000, 4'b0100};
        for (int i = 0; i < 6; i++) begin
            issue(ops[i], 16'hC00F, 16'h0FF0);
            wait_done(0, cyc, busy_n, rw_early);
            n_vec++;
            if (cyc !== 2 || bus.alu2acc !== exp_r[i] || bus.flags !== exp_f[i]
                || bus.acc_alu_io_rw !== 1'b1) begin
                n_err++;
                $display("FAIL op%0d: got cyc=%0d acc=%h flags=%b rw=%b want 2 %h %b 1",
                         ops[i], cyc, bus.alu2acc, bus.flags, bus.acc_alu_io_rw,
                         exp_r[i], exp_f[i]);
            end
        end
    endtask

    task automatic test_mpy();
        int cyc, busy_n, extra;
        bit rw_early;
        issue(OP_MPY, 16'h1234, 16'h0100);
        wait_done(5, cyc, busy_n, rw_early);
        n_vec++;
        if (cyc !== 17 || busy_n !== 17 || rw_early !== 1'b0) begin
            n_err++;
            $display("FAIL mpy_timing: got done_cyc=%0d busy=%0d early_rw=%b want 17/17/0",
                     cyc, busy_n, rw_early);
        end
        n_vec++;
        if (bus.alu2acc !== 16'h3400 || bus.mr_data !== 16'h0012 || bus.acc_alu_io_rw !== 1'b1) begin
            n_err++;
            $display("FAIL mpy_result: got acc=%h mr=%h rw=%b want 3400 0012 1",
                     bus.alu2acc, bus.mr_data, bus.acc_alu_io_rw);
        end
        n_vec++;
        if (bus.flags !== 4'b0010) begin
            n_err++;
            $display("FAIL mpy_flags: got %b want 0010", bus.flags);
        end
        extra = 0;
        repeat (20) begin
            @(negedge clk);
            if (bus.alu_done === 1'b1) extra++;
        end
        n_vec++;
        if (extra !== 0) begin
            n_err++;
            $display("FAIL mpy_ignored_start: got %0d extra done pulses want 0", extra);
        end
        issue(OP_MPY, 16'hFFFF, 16'hFFFF);
        wait_done(0, cyc, busy_n, rw_early);
        n_vec++;
        if (cyc !== 17 || bus.alu2acc !== 16'h0001 || bus.mr_data !== 16'hFFFE
            || bus.flags !== 4'b0010) begin
            n_err++;
            $display("FAIL mpy_max: got cyc=%0d acc=%h mr=%h flags=%b want 17 0001 FFFE 0010",
                     cyc, bus.alu2acc, bus.mr_data, bus.flags);
        end
    endtask

    task automatic test_illegal();
        int cyc, busy_n;
        bit rw_early;
        issue(4'hC, 16'h0001, 16'h0001);
        wait_done(0, cyc, busy_n, rw_early);
        n_vec++;
        if (cyc !== 2 || rw_early !== 1'b0 || bus.acc_alu_io_rw !== 1'b0) begin
            n_err++;
            $display("FAIL illegal_ctl: got cyc=%0d early_rw=%b rw=%b want 2 0 0",
                     cyc, rw_early, bus.acc_alu_io_rw);
        end
        n_vec++;
        if (bus.flags !== 4'b0010 || bus.mr_data !== 16'hFFFE || bus.alu2acc !== 16'h0000) begin
            n_err++;
            $display("FAIL illegal_state: got flags=%b mr=%h acc=%h want 0010 FFFE 0000",
                     bus.flags, bus.mr_data, bus.alu2acc);
        end
    endtask

    task automatic test_back_to_back();
        int cyc, busy_n;
        bit rw_early;
        issue(OP_ADD, 16'h0002, 16'h0003);
        wait_done(0, cyc, busy_n, rw_early);
        issue(OP_LOAD, 16'h0000, 16'hBEEF);
        wait_done(0, cyc, busy_n, rw_early);
        n_vec++;
        if (cyc !== 2 || bus.alu2acc !== 16'hBEEF || bus.flags !== 4'b0100) begin
            n_err++;
            $display("FAIL back_to_back: got cyc=%0d acc=%h flags=%b want 2 BEEF 0100",
                     cyc, bus.alu2acc, bus.flags);
        end
    endtask

    task automatic test_reset_mid_mpy();
        int cyc, busy_n, seen;
        bit rw_early;
        issue(OP_MPY, 16'h1234, 16'h0100);
        repeat (7) @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_vec++;
        if ({bus.alu2acc, bus.mr_data, bus.acc_alu_io_rw, bus.alu_busy, bus.alu_done,
             bus.flags} !== 39'h0) begin
            n_err++;
            $display("FAIL mid_mpy_reset: got acc=%h mr=%h rw=%b busy=%b done=%b flags=%b want 0",
                     bus.alu2acc, bus.mr_data, bus.acc_alu_io_rw, bus.alu_busy,
                     bus.alu_done, bus.flags);
        end
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        repeat (12) begin
            @(negedge clk);
            if (bus.alu_done === 1'b1 || bus.alu_busy === 1'b1) seen++;
        end
        n_vec++;
        if (seen !== 0) begin
            n_err++;
            $display("FAIL post_reset_idle: got %0d busy/done cycles want 0", seen);
        end
        issue(OP_ADD, 16'h0002, 16'h0003);
        wait_done(0, cyc, busy_n, rw_early);
        n_vec++;
        if (cyc !== 2 || bus.alu2acc !== 16'h0005 || bus.flags !== 4'b0000) begin
            n_err++;
            $display("FAIL post_reset_add: got cyc=%0d acc=%h flags=%b want 2 0005 0000",
                     cyc, bus.alu2acc, bus.flags);
        end
    endtask

    initial begin
        n_vec         = 0;
        n_err         = 0;
        rst_n         = 1'b0;
        bus.alu_start = 1'b0;
        bus.alu_op    = 4'h0;
        bus.acc_data  = 16'h0;
        bus.mbr2alu   = 16'h0;
        test_reset();
        test_add_overflow();
        test_sub_shr();
        test_logic_ops();
        test_mpy();
        test_illegal();
        test_back_to_back();
        test_reset_mid_mpy();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

endmodule

`default_nettype wire
